core_ctrl: RTL and testbench
============================

CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- PC_ADDR_WIDTH, 8, program-counter and program-address width.
- DATA_WIDTH, 16, instruction width.
- WAIT_TIMEOUT, 255, maximum WAIT-state cycles before abort.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch request, level-sampled in IDLE/DONE.
- next_pc  in  PC_ADDR_WIDTH  from pc block.
- prog_rsp_valid  in  1  program-memory response valid.
- prog_rsp_data  in  DATA_WIDTH  fetched instruction.
- lsu_done  in  1  load/store completion pulse.
- prog_req_valid  out  1  fetch request.
- prog_req_addr  out  PC_ADDR_WIDTH  fetch address, equals curr_pc.
- instr  out  DATA_WIDTH  latched instruction.
- opcode  out  4  instr[15:12].
- lsu_req  out  1  one-cycle load/store launch pulse.
- cu_state  out  4  current state encoding.
- pc_en  out  1  pc block enable.
- curr_pc  out  PC_ADDR_WIDTH  PC of the instruction in flight.
- busy  out  1  state not IDLE/DONE.
- done  out  1  state is DONE.
- error  out  1  sticky WAIT-timeout flag.

Function
REQ-003 States SHALL be IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7; cu_state SHALL be the registered state.
REQ-004 IDLE: on start=1, curr_pc<=0, error<=0, go to FETCH; otherwise stay.
REQ-005 FETCH: prog_req_valid=1 with prog_req_addr=curr_pc until prog_rsp_valid=1; on that cycle instr<=prog_rsp_data and state becomes DECODE; prog_req_valid SHALL be 0 in every other state.
REQ-006 DECODE SHALL last exactly one cycle, then go to REQUEST.
REQ-007 REQUEST SHALL last exactly one cycle.
- If opcode is LDR or STR: lsu_req=1 in this cycle only, then go to WAIT.
- Otherwise go to EXECUTE.
REQ-008 WAIT: hold until lsu_done=1, then go to EXECUTE.
- An 8-bit-minimum counter SHALL clear on entry and increment each WAIT cycle.
- When the count reaches WAIT_TIMEOUT without lsu_done: error<=1, go to DONE.
- lsu_done on the timeout cycle SHALL take priority (go to EXECUTE, error unchanged).
REQ-009 EXECUTE SHALL last exactly one cycle, then go to UPDATE.
REQ-010 UPDATE SHALL last exactly one cycle.
- If opcode==RET: go to DONE with curr_pc unchanged.
- Otherwise curr_pc<=next_pc and go to FETCH.
REQ-011 DONE: done=1.
- On start=1, curr_pc<=0, error<=0, go to FETCH.
- Otherwise hold.
REQ-012 pc_en SHALL be 1 in FETCH through UPDATE and 0 in IDLE and DONE.
REQ-013 Latency, non-memory instruction with same-cycle prog_rsp_valid: exactly 5 cycles FETCH-entry to next FETCH-entry. Memory instruction: 6 + WAIT cycles beyond the first.
REQ-014 Ignore rules:
- start is ignored while busy=1.
- prog_rsp_valid outside FETCH is ignored.
- lsu_done outside WAIT is ignored.
REQ-015 curr_pc SHALL take next_pc unmodified (natural wrap at 2^PC_ADDR_WIDTH); no range check.
REQ-016 opcode SHALL be combinational from registered instr; all other outputs SHALL be registered or decoded from state only.

Reset
REQ-017 reset SHALL put the block in IDLE on the next edge from any state, including mid-FETCH/WAIT.
- Reset values: curr_pc=0, instr=0, error=0, wait counter=0, all strobes=0.
- Reset SHALL override start, prog_rsp_valid and lsu_done on the same edge.

Structure
REQ-018 State encodings and opcode constants SHALL live in shared package core_pkg: BNE=4, BEQ=5, BLT=6, BGT=7, CMP alu func=8, LDR=9, STR=10, RET=15.
- pc and core_ctrl SHALL both use core_pkg.
REQ-019 The WAIT-timeout counter SHALL be sub-module wait_timer (clear, enable, expired); no other sub-modules.

Verification
REQ-020 Directed scenarios:
- ADD@0, RET@2, zero-latency memory, next_pc=2 then 4 -> FETCH entries 5 cycles apart, curr_pc 0 then 2, done=1 after second UPDATE, curr_pc stays 2.
- LDR@0, lsu_done 3 cycles after lsu_req -> lsu_req high exactly one cycle, EXECUTE entered the cycle after lsu_done, pc_en continuously 1.
- STR with no lsu_done, WAIT_TIMEOUT=4 -> DONE after 4 WAIT cycles, error=1; a later start clears error and fetches at address 0.
- Fetch with prog_rsp_valid delayed 7 cycles -> prog_req_valid/addr stable for 7 cycles, instr captured on the response cycle only.
- reset asserted in WAIT with lsu_done high the same cycle -> IDLE next cycle, all outputs at reset values, no EXECUTE.
- start pulsed while busy, plus a stray lsu_done in FETCH -> no state or curr_pc change.

Source files
------------

// File: rtl/core_pkg.sv
// Shared controller definitions: FSM state encodings, opcode constants, helpers.
package core_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_REQUEST = 4'd3,
    ST_WAIT    = 4'd4,
    ST_EXECUTE = 4'd5,
    ST_UPDATE  = 4'd6,
    ST_DONE    = 4'd7
  } state_t;

  localparam logic [3:0] OP_BNE = 4'd4;
  localparam logic [3:0] OP_BEQ = 4'd5;
  localparam logic [3:0] OP_BLT = 4'd6;
  localparam logic [3:0] OP_BGT = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_LDR = 4'd9;
  localparam logic [3:0] OP_STR = 4'd10;
  localparam logic [3:0] OP_RET = 4'd15;

  // Loads and stores are the only opcodes that go through the LSU handshake.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// Program-memory fetch and LSU handshake bundle between controller and its peers.
interface core_ctrl_if #(
  parameter int PC_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH    = 16
);
  logic                     prog_req_valid;
  logic [PC_ADDR_WIDTH-1:0] prog_req_addr;
  logic                     prog_rsp_valid;
  logic [DATA_WIDTH-1:0]    prog_rsp_data;
  logic                     lsu_req;
  logic                     lsu_done;

  // Controller side.
  modport master (
    output prog_req_valid, prog_req_addr, lsu_req,
    input  prog_rsp_valid, prog_rsp_data, lsu_done
  );

  // Memory / LSU side.
  modport slave (
    input  prog_req_valid, prog_req_addr, lsu_req,
    output prog_rsp_valid, prog_rsp_data, lsu_done
  );
endinterface

// File: rtl/core_ctrl_wait_timer.sv
// WAIT-state watchdog: counts cycles while enabled, flags the last allowed cycle.
module wait_timer #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [WIDTH-1:0] cnt;

  // Count enabled cycles; clear wins so the count restarts at zero on WAIT entry.
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (enable)    cnt <= cnt + 1'b1;
  end

  // Asserted during the LIMIT-th enabled cycle, i.e. the one whose increment reaches LIMIT.
  assign expired = enable && (cnt == WIDTH'(LIMIT - 1));
endmodule

// File: rtl/core_ctrl.sv
// Core control unit: sequences fetch, decode, LSU request/wait, execute and PC update.
module core_ctrl
  import core_pkg::*;
#(
  parameter int PC_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int WAIT_TIMEOUT  = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PC_ADDR_WIDTH-1:0] next_pc,
  core_ctrl_if.master              bus,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [3:0]               opcode,
  output logic [3:0]               cu_state,
  output logic                     pc_en,
  output logic [PC_ADDR_WIDTH-1:0] curr_pc,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);
  localparam int CLOG  = $clog2(WAIT_TIMEOUT + 1);
  localparam int CNT_W = (CLOG > 8) ? CLOG : 8;

  state_t state, state_n;
  logic   expired;
  logic   lsu_req_q;

  wait_timer #(.WIDTH(CNT_W), .LIMIT(WAIT_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ST_WAIT),
    .enable  (state == ST_WAIT),
    .expired (expired)
  );

  assign opcode = instr[15:12];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state decode; lsu_done beats the watchdog on the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE,
      ST_DONE:    if (start) state_n = ST_FETCH;
      ST_FETCH:   if (bus.prog_rsp_valid) state_n = ST_DECODE;
      ST_DECODE:  state_n = ST_REQUEST;
      ST_REQUEST: state_n = is_mem_op(opcode) ? ST_WAIT : ST_EXECUTE;
      ST_WAIT: begin
        if (bus.lsu_done)  state_n = ST_EXECUTE;
        else if (expired)  state_n = ST_DONE;
      end
      ST_EXECUTE: state_n = ST_UPDATE;
      ST_UPDATE:  state_n = (opcode == OP_RET) ? ST_DONE : ST_FETCH;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Datapath registers: PC, instruction latch, sticky error, LSU launch pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      curr_pc   <= '0;
      instr     <= '0;
      error     <= 1'b0;
      lsu_req_q <= 1'b0;
    end else begin
      if ((state == ST_IDLE || state == ST_DONE) && start) begin
        curr_pc <= '0;
        error   <= 1'b0;
      end
      if (state == ST_FETCH && bus.prog_rsp_valid) instr <= bus.prog_rsp_data;
      if (state == ST_WAIT && !bus.lsu_done && expired) error <= 1'b1;
      if (state == ST_UPDATE && opcode != OP_RET) curr_pc <= next_pc;
      // DECODE always falls into REQUEST, so this pulse covers exactly the REQUEST cycle.
      lsu_req_q <= (state == ST_DECODE) && is_mem_op(opcode);
    end
  end

  assign cu_state           = state;
  assign busy               = (state != ST_IDLE) && (state != ST_DONE);
  assign pc_en              = busy;
  assign done               = (state == ST_DONE);
  assign bus.prog_req_valid = (state == ST_FETCH);
  assign bus.prog_req_addr  = curr_pc;
  assign bus.lsu_req        = lsu_req_q;
endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: fetch/decode sequencing, LSU wait, timeout, reset, ignore rules.
module tb_core_ctrl;
  localparam int PW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [PW-1:0] next_pc;
  logic [DW-1:0] instr;
  logic [3:0]    opcode, cu_state;
  logic          pc_en, busy, done, error;
  logic [PW-1:0] curr_pc;
  logic [DW-1:0] prog [0:255];

  int errors = 0;
  int checks = 0;

  core_ctrl_if #(.PC_ADDR_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

  core_ctrl #(.PC_ADDR_WIDTH(PW), .DATA_WIDTH(DW), .WAIT_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .next_pc(next_pc), .bus(bus),
    .instr(instr), .opcode(opcode), .cu_state(cu_state), .pc_en(pc_en),
    .curr_pc(curr_pc), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  assign bus.prog_rsp_data = prog[bus.prog_req_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = '0;
    reset = 1'b1; start = 1'b0; next_pc = '0;
    bus.prog_rsp_valid = 1'b0; bus.lsu_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", 32'(cu_state), 0);
    chk("rst_pc", 32'(curr_pc), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_err", 32'(error), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pcen", 32'(pc_en), 0);
    chk("rst_reqv", 32'(bus.prog_req_valid), 0);
    chk("rst_lsureq", 32'(bus.lsu_req), 0);

    // ADD@0, RET@2, same-cycle responses.
    prog[0] = 16'h1234; prog[2] = 16'hF000;
    bus.prog_rsp_valid = 1'b1; next_pc = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    chk("s1_fetch", 32'(cu_state), 1);
    chk("s1_reqv", 32'(bus.prog_req_valid), 1);
    chk("s1_addr", 32'(bus.prog_req_addr), 0);
    tick();
    chk("s1_decode", 32'(cu_state), 2);
    chk("s1_instr", 32'(instr), 32'h1234);
    chk("s1_opcode", 32'(opcode), 1);
    tick();
    chk("s1_request", 32'(cu_state), 3);
    chk("s1_nolsu", 32'(bus.lsu_req), 0);
    tick(); chk("s1_exec", 32'(cu_state), 5);
    tick(); chk("s1_update", 32'(cu_state), 6);
    tick();
    chk("s1_fetch2", 32'(cu_state), 1);
    chk("s1_pc2", 32'(curr_pc), 2);
    next_pc = 8'd4;
    repeat (4) tick();
    chk("s1_update2", 32'(cu_state), 6);
    tick();
    chk("s1_done", 32'(done), 1);
    chk("s1_donepc", 32'(curr_pc), 2);
    chk("s1_donebusy", 32'(busy), 0);
    chk("s1_donepcen", 32'(pc_en), 0);
    repeat (3) tick();
    chk("s1_hold", 32'(cu_state), 7);
    chk("s1_holdpc", 32'(curr_pc), 2);

    // LDR@0, lsu_done three cycles after lsu_req; RET@16 ends the run.
    prog[0] = 16'h9000; prog[16] = 16'hF000; next_pc = 8'd16; start = 1'b1;
    tick(); start = 1'b0;
    chk("s2_fetch", 32'(cu_state), 1);
    chk("s2_pc", 32'(curr_pc), 0);
    tick(); chk("s2_pcen_d", 32'(pc_en), 1);
    tick();
    chk("s2_lsureq", 32'(bus.lsu_req), 1);
    chk("s2_pcen_r", 32'(pc_en), 1);
    tick();
    chk("s2_wait", 32'(cu_state), 4);
    chk("s2_lsureq_off", 32'(bus.lsu_req), 0);
    tick(); chk("s2_pcen_w", 32'(pc_en), 1);
    tick(); chk("s2_wait3", 32'(cu_state), 4);
    bus.lsu_done = 1'b1;
    tick(); bus.lsu_done = 1'b0;
    chk("s2_exec", 32'(cu_state), 5);
    chk("s2_lsureq_x", 32'(bus.lsu_req), 0);
    for (int i = 0; i < 6; i++) begin
      tick(); chk("s2_pcen_run", 32'(pc_en), 1);
    end
    tick();
    chk("s2_done", 32'(cu_state), 7);
    chk("s2_donepc", 32'(curr_pc), 16);

    // STR@0, no lsu_done: timeout after 4 WAIT cycles.
    prog[0] = 16'hA000; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    chk("s3_lsureq", 32'(bus.lsu_req), 1);
    tick(); tick(); tick();
    tick();
    chk("s3_wait4", 32'(cu_state), 4);
    chk("s3_noerr", 32'(error), 0);
    tick();
    chk("s3_done", 32'(cu_state), 7);
    chk("s3_err", 32'(error), 1);

    // Restart clears error; fetch response withheld for 7 cycles.
    prog[0] = 16'h1111; bus.prog_rsp_valid = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("s4_errclr", 32'(error), 0);
    chk("s4_pc", 32'(curr_pc), 0);
    for (int i = 0; i < 7; i++) begin
      chk("s4_stall_st", 32'(cu_state), 1);
      chk("s4_stall_v", 32'(bus.prog_req_valid), 1);
      chk("s4_stall_a", 32'(bus.prog_req_addr), 0);
      chk("s4_stall_i", 32'(instr), 32'hA000);
      tick();
    end
    bus.prog_rsp_valid = 1'b1;
    chk("s4_pre_i", 32'(instr), 32'hA000);
    tick();
    chk("s4_decode", 32'(cu_state), 2);
    chk("s4_instr", 32'(instr), 32'h1111);
    prog[0] = 16'h2222;
    tick();
    chk("s4_ignore_rsp", 32'(instr), 32'h1111);
    chk("s4_reqv_off", 32'(bus.prog_req_valid), 0);
    bus.prog_rsp_valid = 1'b0;

    // Reset in WAIT with lsu_done on the same edge.
    reset = 1'b1; tick(); reset = 1'b0;
    prog[0] = 16'h9000; bus.prog_rsp_valid = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("s5_inwait", 32'(cu_state), 4);
    reset = 1'b1; bus.lsu_done = 1'b1;
    tick();
    chk("s5_idle", 32'(cu_state), 0);
    chk("s5_pc", 32'(curr_pc), 0);
    chk("s5_instr", 32'(instr), 0);
    chk("s5_err", 32'(error), 0);
    chk("s5_lsureq", 32'(bus.lsu_req), 0);
    chk("s5_reqv", 32'(bus.prog_req_valid), 0);
    chk("s5_busy", 32'(busy), 0);
    chk("s5_pcen", 32'(pc_en), 0);
    reset = 1'b0; bus.lsu_done = 1'b0;
    tick();
    chk("s5_stay", 32'(cu_state), 0);

    // start while busy and stray lsu_done in FETCH change nothing.
    prog[0] = 16'h1234; next_pc = 8'd6; start = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    chk("s6_fetch", 32'(cu_state), 1);
    chk("s6_pc", 32'(curr_pc), 6);
    bus.prog_rsp_valid = 1'b0; start = 1'b1; bus.lsu_done = 1'b1;
    tick();
    chk("s6_st1", 32'(cu_state), 1);
    chk("s6_pc1", 32'(curr_pc), 6);
    tick();
    chk("s6_st2", 32'(cu_state), 1);
    chk("s6_pc2", 32'(curr_pc), 6);
    chk("s6_busy", 32'(busy), 1);
    start = 1'b0; bus.lsu_done = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
